// File: rtl/popcount_accumulator.sv
// Sums WINDOW_LEN valid popcount samples into one result, offered on a valid/ready output.
// Out-of-range samples saturate to 8 and raise a sticky range error.
module popcount_accumulator #(
    parameter int WINDOW_LEN = 16,
    parameter int ACC_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clear,
    input  logic [3:0]           count_in,
    input  logic                 count_valid,
    input  logic                 result_ready,
    output logic                 busy,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 result_valid,
    output logic                 range_err,
    output logic [1:0]           dbg_state
);

    localparam int CNT_W = $clog2(WINDOW_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_result;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_range_err;
    logic                 w_over;
    logic [3:0]           w_sample;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_take;
    logic                 w_last;

    assign w_over   = (count_in > 4'd8);
    assign w_sample = w_over ? 4'd8 : count_in;
    assign w_sum    = r_acc + ACC_WIDTH'(w_sample);
    assign w_take   = (r_state == S_ACCUM) && count_valid;
    assign w_last   = w_take && (r_cnt == CNT_W'(WINDOW_LEN - 1));

    // Output handshake: result is offered while result_valid is high and is
    // taken on a cycle with result_ready=1 and clear=0.
    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start)        w_next = S_ACCUM;
                S_ACCUM: if (w_last)       w_next = S_DONE;
                S_DONE:  if (result_ready) w_next = S_IDLE;
                default:                   w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_range_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (clear) begin
                // Abort keeps the last result and the error flag for inspection.
                r_acc <= '0;
                r_cnt <= '0;
            end else if ((r_state == S_IDLE) && start) begin
                r_acc       <= '0;
                r_cnt       <= '0;
                r_range_err <= 1'b0;
            end else if (w_take) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_over) r_range_err <= 1'b1;
                if (w_last) r_result <= w_sum;
            end
        end
    end

    assign busy         = (r_state == S_ACCUM);
    assign result_valid = (r_state == S_DONE);
    assign result       = r_result;
    assign range_err    = r_range_err;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_popcount_accumulator.sv
// Bench for popcount_accumulator: table of full windows plus hand-written
// sequences for backpressure, range error, abort, clear-in-DONE and async reset.
module tb_popcount_accumulator;

    localparam int W  = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [3:0]    count_in = 4'd0;
    logic          count_valid = 1'b0;
    logic          result_ready = 1'b0;
    logic          busy;
    logic [AW-1:0] result;
    logic          result_valid;
    logic          range_err;
    logic [1:0]    dbg_state;

    popcount_accumulator #(.WINDOW_LEN(W), .ACC_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .count_in(count_in), .count_valid(count_valid), .result_ready(result_ready),
        .busy(busy), .result(result), .result_valid(result_valid),
        .range_err(range_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [AW-1:0] exp_q[$];

    typedef struct {
        logic [3:0]    val;
        bit            gap;
        logic [AW-1:0] exp_res;
        bit            exp_err;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a result is consumed on a cycle with valid, ready and no clear.
    always @(negedge clk) begin
        if (rst_n && result_valid && result_ready && !clear) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(result), 32'hFFFF_FFFF);
            end else begin
                check("sb_result", 32'(result), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic feed(input logic [3:0] val, input bit gap);
        for (int i = 0; i < W; i++) begin
            count_in    = val;
            count_valid = 1'b1;
            step();
            count_valid = 1'b0;
            if (gap && i != W - 1) step();
        end
    endtask

    task automatic accept();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check("idle_after_accept", 32'(dbg_state), 32'd0);
        check("valid_low_after_accept", 32'(result_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        vecs[0] = '{4'd8, 1'b0, 8'd128, 1'b0};
        vecs[1] = '{4'd3, 1'b1, 8'd48,  1'b0};
        vecs[2] = '{4'd0, 1'b0, 8'd0,   1'b0};
        vecs[3] = '{4'd5, 1'b1, 8'd80,  1'b0};
        vecs[4] = '{4'd15, 1'b0, 8'd128, 1'b1};
        vecs[5] = '{4'd9, 1'b1, 8'd128, 1'b1};
        for (int i = 6; i < 8; i++) begin
            r = $urandom_range(0, 8);
            vecs[i] = '{4'(r), bit'(i % 2), 8'(r * 16), 1'b0};
        end

        // Reset state
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_range_err", 32'(range_err), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 8; v++) begin
            do_start();
            exp_q.push_back(vecs[v].exp_res);
            feed(vecs[v].val, vecs[v].gap);
            check("valid_one_after_last", 32'(result_valid), 32'd1);
            check("busy_low_in_done", 32'(busy), 32'd0);
            check("vec_range_err", 32'(range_err), 32'(vecs[v].exp_err));
            accept();
        end

        // Backpressure: start and samples in DONE are ignored
        do_start();
        exp_q.push_back(8'd48);
        feed(4'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            start       = (i % 2 == 0);
            count_valid = (i % 2 == 1);
            count_in    = 4'd8;
            step();
            check("bp_result", 32'(result), 32'd48);
            check("bp_valid", 32'(result_valid), 32'd1);
            check("bp_busy", 32'(busy), 32'd0);
        end
        start = 1'b0;
        count_valid = 1'b0;
        accept();
        step();
        check("bp_no_restart", 32'(dbg_state), 32'd0);

        // Range error from one out-of-range sample mid-window
        do_start();
        exp_q.push_back(8'd8);
        for (int i = 0; i < W; i++) begin
            count_in    = (i == 7) ? 4'd12 : 4'd0;
            count_valid = 1'b1;
            step();
        end
        count_valid = 1'b0;
        check("re_valid", 32'(result_valid), 32'd1);
        check("re_err_set", 32'(range_err), 32'd1);
        accept();
        check("re_err_sticky_idle", 32'(range_err), 32'd1);
        do_start();
        check("re_err_cleared", 32'(range_err), 32'd0);

        // Abort: clear beats start after 7 samples; result keeps its value
        for (int i = 0; i < 7; i++) begin
            count_in = 4'd1;
            count_valid = 1'b1;
            step();
        end
        count_valid = 1'b0;
        clear = 1'b1;
        start = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_idle", 32'(dbg_state), 32'd0);
        check("abort_result_kept", 32'(result), 32'd8);
        step();
        check("abort_start_dropped", 32'(dbg_state), 32'd0);
        do_start();
        exp_q.push_back(8'd16);
        feed(4'd1, 1'b0);
        check("abort_next_valid", 32'(result_valid), 32'd1);
        accept();

        // Clear together with ready in DONE: transfer not taken
        do_start();
        feed(4'd2, 1'b0);
        check("cd_valid", 32'(result_valid), 32'd1);
        clear = 1'b1;
        result_ready = 1'b1;
        step();
        clear = 1'b0;
        result_ready = 1'b0;
        check("cd_idle", 32'(dbg_state), 32'd0);
        check("cd_valid_low", 32'(result_valid), 32'd0);
        check("cd_result_kept", 32'(result), 32'd32);

        // Async reset mid-window (with range_err set) then in DONE
        do_start();
        for (int i = 0; i < 5; i++) begin
            count_in = (i == 2) ? 4'd9 : 4'd4;
            count_valid = 1'b1;
            step();
        end
        count_valid = 1'b0;
        check("ar_err_before", 32'(range_err), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_mid_busy", 32'(busy), 32'd0);
        check("ar_mid_err", 32'(range_err), 32'd0);
        check("ar_mid_result", 32'(result), 32'd0);
        step();
        rst_n = 1'b1;
        do_start();
        feed(4'd4, 1'b0);
        check("ar_done_result", 32'(result), 32'd64);
        #2 rst_n = 1'b0;
        #1;
        check("ar_done_valid", 32'(result_valid), 32'd0);
        check("ar_done_result0", 32'(result), 32'd0);
        check("ar_done_state", 32'(dbg_state), 32'd0);
        step();
        rst_n = 1'b1;
        do_start();
        exp_q.push_back(8'd16);
        feed(4'd1, 1'b1);
        accept();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
